apb_req_arbiter: RTL and testbench

- Two-port APB master that shares one APB bus between two local requesters (e.g. test sequencer and config loader) targeting the student-info register slave.
- Arbitrates round-robin, runs the APB SETUP/ACCESS sequence, waits for PREADY, returns read data and a one-cycle completion pulse to the granted requester.
- Sits between the requesters and the slave's PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY pins.

---
 rtl/apb_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between two local requesters.
// Optional: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_req_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                req0_elig, req1_elig;
    logic                winner;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            err0_q, err0_d;
    logic            err1_q, err1_d;
    logic            tmo_hit;

    assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign err0    = err0_q;
    assign err1    = err1_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    // A port whose done is showing still holds req; mask it so it is not issued twice.
    assign req0_elig = req0 & ~done0_q;
    assign req1_elig = req1 & ~done1_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        winner       = 1'b0;
`ifdef APB_TIMEOUT_EN
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        tmo_cnt_d    = tmo_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req0_elig || req1_elig) begin
                    winner   = (req0_elig && req1_elig) ? ~last_grant_q : req1_elig;
                    grant_d  = winner;
                    pwrite_d = winner ? we1 : we0;
                    paddr_d  = winner ? addr1 : addr0;
                    pwdata_d = winner ? wdata1 : wdata0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            StAccess: begin
                if (PREADY) begin
                    if (!pwrite_q) begin
                        if (grant_q) rdata1_d = PRDATA;
                        else         rdata0_d = PRDATA;
                    end
                    done0_d      = ~grant_q;
                    done1_d      = grant_q;
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_hit) begin
                    done0_d      = ~grant_q;
                    done1_d      = grant_q;
                    err0_d       = ~grant_q;
                    err1_d       = grant_q;
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CntW'(1);
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
`ifdef APB_TIMEOUT_EN
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
`ifdef APB_TIMEOUT_EN
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign busy    = (state_q != StIdle);
    assign PSEL    = (state_q != StIdle);
    assign PENABLE = (state_q == StAccess);
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus randomized two-port traffic
// checked against a transaction-level round-robin model. Cycle n = n-th edge after req rises.
`timescale 1ns/1ps
module tb_apb_req_arbiter;

    logic        PCLK, PRESETn;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] cont_wd [3];

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave: 16-word memory, PREADY after slave_wait low ACCESS cycles.
    logic [31:0] mem [16] = '{default: '0};
    int unsigned slave_wait = 0;
    int unsigned acc_cnt = 0;
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;
    end
    assign PREADY = PSEL && PENABLE && (acc_cnt >= slave_wait);
    assign PRDATA = mem[PADDR[5:2]];

    task automatic test_reset();
        PRESETn = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, busy} !== 4'b0) $display("FAIL reset_ctrl: got %b expected 0000", {PSEL, PENABLE, PWRITE, busy});
        else n_pass++;
        n_checks++;
        if ({PADDR, PWDATA} !== 64'h0) $display("FAIL reset_bus: got %h expected 0", {PADDR, PWDATA});
        else n_pass++;
        n_checks++;
        if ({done0, done1, err0, err1} !== 4'b0) $display("FAIL reset_done: got %b expected 0000", {done0, done1, err0, err1});
        else n_pass++;
        n_checks++;
        if ({rdata0, rdata1} !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1});
        else n_pass++;
        PRESETn = 1'b1;
        @(negedge PCLK);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_single_write();
        slave_wait = 0;
        req0 = 1; we0 = 1; addr0 = 32'h4; wdata0 = 32'h1210_2024;
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101) $display("FAIL wr_setup_ctrl: got %b expected 101", {PSEL, PENABLE, PWRITE});
        else n_pass++;
        n_checks++;
        if (PADDR !== 32'h4 || PWDATA !== 32'h1210_2024) $display("FAIL wr_setup_bus: got %h/%h expected 4/12102024", PADDR, PWDATA);
        else n_pass++;
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b11) $display("FAIL wr_access_ctrl: got %b expected 11", {PSEL, PENABLE});
        else n_pass++;
        n_checks++;
        if (PADDR !== 32'h4 || PWDATA !== 32'h1210_2024) $display("FAIL wr_access_bus: got %h/%h expected 4/12102024", PADDR, PWDATA);
        else n_pass++;
        @(negedge PCLK);
        n_checks++;
        if ({done0, err0, done1, PSEL} !== 4'b1000) $display("FAIL wr_done: got %b expected 1000", {done0, err0, done1, PSEL});
        else n_pass++;
        req0 = 0;
        @(negedge PCLK);
        n_checks++;
        if ({done0, PSEL} !== 2'b00) $display("FAIL wr_done_once: got %b expected 00", {done0, PSEL});
        else n_pass++;
    endtask

    task automatic test_read_back();
        bit got = 0;
        req1 = 1; we1 = 0; addr1 = 32'h4;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge PCLK);
            if (done1 === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) $display("FAIL rd_done_seen: got 0 expected 1");
        else n_pass++;
        n_checks++;
        if (rdata1 !== 32'h1210_2024) $display("FAIL rd_data: got %h expected 12102024", rdata1);
        else n_pass++;
        n_checks++;
        if (rdata0 !== 32'h0) $display("FAIL rd_other_port: got %h expected 0", rdata0);
        else n_pass++;
        req1 = 0;
        repeat (3) @(negedge PCLK);
        n_checks++;
        if (rdata1 !== 32'h1210_2024) $display("FAIL rd_hold: got %h expected 12102024", rdata1);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [31:0] a [3];
        int order[$];
        int i0 = 0, i1 = 0;
        a[0] = 32'h0; a[1] = 32'h8; a[2] = 32'hC;
        for (int k = 0; k < 3; k++) cont_wd[k] = $urandom;
        PRESETn = 0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1;
        req0 = 1; we0 = 1; addr0 = a[0]; wdata0 = cont_wd[0];
        req1 = 1; we1 = 0; addr1 = a[0];
        for (int c = 0; c < 80 && (i0 < 3 || i1 < 3); c++) begin
            @(negedge PCLK);
            if (done0 === 1'b1 || done1 === 1'b1) begin
                n_checks++;
                if (done0 === 1'b1 && done1 === 1'b1) $display("FAIL cont_overlap: got done0=1 done1=1 expected one");
                else n_pass++;
                if (done1 === 1'b1) begin
                    n_checks++;
                    if (rdata1 !== cont_wd[i1]) $display("FAIL cont_rdata%0d: got %h expected %h", i1, rdata1, cont_wd[i1]);
                    else n_pass++;
                    order.push_back(1);
                    i1++;
                    if (i1 < 3) addr1 = a[i1];
                    else        req1 = 0;
                end else begin
                    order.push_back(0);
                    i0++;
                    if (i0 < 3) begin addr0 = a[i0]; wdata0 = cont_wd[i0]; end
                    else        req0 = 0;
                end
            end
        end
        n_checks++;
        if (order.size() != 6) $display("FAIL cont_count: got %0d expected 6", order.size());
        else n_pass++;
        for (int k = 0; k < order.size(); k++) begin
            n_checks++;
            if (order[k] != k % 2) $display("FAIL cont_order%0d: got %0d expected %0d", k, order[k], k % 2);
            else n_pass++;
        end
        req0 = 0; req1 = 0;
        @(negedge PCLK);
    endtask

    task automatic test_wait_states();
        int n_acc = 0;
        bit stable = 1;
        bit early = 0;
        logic [31:0] wd;
        wd = $urandom;
        slave_wait = 5;
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = wd;
        for (int i = 0; i < 10 && PENABLE !== 1'b1; i++) @(negedge PCLK);
        while (PENABLE === 1'b1 && n_acc < 20) begin
            n_acc++;
            if (PSEL !== 1'b1 || PADDR !== 32'h10 || PWDATA !== wd || PWRITE !== 1'b1) stable = 0;
            if (done0 === 1'b1 || (PREADY === 1'b1 && n_acc != 6)) early = 1;
            @(negedge PCLK);
        end
        n_checks++;
        if (n_acc != 6) $display("FAIL ws_access_len: got %0d expected 6", n_acc);
        else n_pass++;
        n_checks++;
        if (!stable) $display("FAIL ws_stable: got unstable bus expected stable");
        else n_pass++;
        n_checks++;
        if (early) $display("FAIL ws_early: got early ready/done expected none");
        else n_pass++;
        n_checks++;
        if ({done0, PSEL} !== 2'b10) $display("FAIL ws_done: got %b expected 10", {done0, PSEL});
        else n_pass++;
        req0 = 0;
        slave_wait = 0;
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid_access();
        bit got0 = 0, got1 = 0;
        slave_wait = 1000;
        req0 = 1; we0 = 0; addr0 = 32'h4;
        for (int i = 0; i < 10 && PENABLE !== 1'b1; i++) @(negedge PCLK);
        PRESETn = 0;
        req1 = 1; we1 = 1; addr1 = 32'h14; wdata1 = $urandom;
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, busy, done0, done1} !== 5'b0) $display("FAIL rst_abort: got %b expected 00000", {PSEL, PENABLE, busy, done0, done1});
        else n_pass++;
        PRESETn = 1;
        slave_wait = 0;
        @(negedge PCLK);
        n_checks++;
        if (PSEL !== 1'b1 || PADDR !== 32'h4 || PWRITE !== 1'b0) $display("FAIL rst_reissue: got %b/%h/%b expected 1/4/0", PSEL, PADDR, PWRITE);
        else n_pass++;
        for (int i = 0; i < 10 && !got0; i++) begin
            @(negedge PCLK);
            if (done0 === 1'b1) got0 = 1;
        end
        n_checks++;
        if (!got0 || rdata0 !== 32'h1210_2024) $display("FAIL rst_port0_read: got %b/%h expected 1/12102024", got0, rdata0);
        else n_pass++;
        req0 = 0;
        for (int i = 0; i < 10 && !got1; i++) begin
            @(negedge PCLK);
            if (done1 === 1'b1) got1 = 1;
        end
        n_checks++;
        if (!got1) $display("FAIL rst_port1_done: got 0 expected 1");
        else n_pass++;
        req1 = 0;
        @(negedge PCLK);
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int n_acc = 0;
        bit got = 0;
        slave_wait = 1000;
        req0 = 1; we0 = 0; addr0 = 32'h8;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge PCLK);
            if (PENABLE === 1'b1) n_acc++;
            if (done0 === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || n_acc != 16) $display("FAIL tmo_len: got done=%b acc=%0d expected 1/16", got, n_acc);
        else n_pass++;
        n_checks++;
        if ({err0, PSEL, done1, err1} !== 4'b1000) $display("FAIL tmo_flags: got %b expected 1000", {err0, PSEL, done1, err1});
        else n_pass++;
        n_checks++;
        if (rdata0 !== 32'h1210_2024) $display("FAIL tmo_rdata: got %h expected 12102024", rdata0);
        else n_pass++;
        req0 = 0;
        slave_wait = 0;
        @(negedge PCLK);
    endtask
`else
    task automatic test_no_timeout();
        bit early = 0;
        bit got = 0;
        slave_wait = 1000;
        req0 = 1; we0 = 0; addr0 = 32'h8;
        repeat (40) begin
            @(negedge PCLK);
            if (done0 === 1'b1 || err0 === 1'b1) early = 1;
        end
        n_checks++;
        if (early || {PSEL, PENABLE} !== 2'b11) $display("FAIL notmo_wait: got early=%b ctrl=%b expected 0/11", early, {PSEL, PENABLE});
        else n_pass++;
        slave_wait = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge PCLK);
            if (done0 === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || err0 !== 1'b0 || rdata0 !== cont_wd[1]) $display("FAIL notmo_done: got %b/%b/%h expected 1/0/%h", got, err0, rdata0, cont_wd[1]);
        else n_pass++;
        req0 = 0;
        @(negedge PCLK);
    endtask
`endif

    task automatic test_random();
        txn_t q0[$], q1[$];
        txn_t t;
        logic [31:0] mmem [16];
        logic [31:0] mrd [2];
        bit prev_req [2];
        bit prev_done [2];
        bit prev_psel = 0;
        bit mlast = 1;
        int owner = -1;
        int p;
        bit c0, c1, exp_w;
        bit fin0, fin1;
        for (int k = 0; k < 16; k++) mmem[k] = '0;
        mrd[0] = '0; mrd[1] = '0;
        prev_req[0] = 0; prev_req[1] = 0; prev_done[0] = 0; prev_done[1] = 0;
        for (int k = 0; k < 12; k++) begin
            t.we = 1'($urandom_range(0, 1)); t.addr = 32'h20 + 4 * $urandom_range(0, 7); t.data = $urandom;
            q0.push_back(t);
            t.we = 1'($urandom_range(0, 1)); t.addr = 32'h20 + 4 * $urandom_range(0, 7); t.data = $urandom;
            q1.push_back(t);
        end
        PRESETn = 0; req0 = 0; req1 = 0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1;
        for (int cyc = 0; cyc < 3000 && (q0.size() != 0 || q1.size() != 0); cyc++) begin
            @(negedge PCLK);
            fin0 = 0; fin1 = 0;
            if (PSEL === 1'b1 && !prev_psel) begin
                c0 = prev_req[0] && !prev_done[0];
                c1 = prev_req[1] && !prev_done[1];
                exp_w = (c0 && c1) ? !mlast : c1;
                t = exp_w ? q1[0] : q0[0];
                n_checks++;
                if (!(c0 || c1) || PADDR !== t.addr || PWRITE !== t.we || (t.we && PWDATA !== t.data))
                    $display("FAIL rnd_grant: got %h/%b/%h expected port %0d %h/%b/%h", PADDR, PWRITE, PWDATA, exp_w, t.addr, t.we, t.data);
                else n_pass++;
                owner = int'(exp_w);
                slave_wait = $urandom_range(0, 3);
            end
            if (done0 === 1'b1 || done1 === 1'b1) begin
                p = (done1 === 1'b1) ? 1 : 0;
                n_checks++;
                if ((done0 === 1'b1 && done1 === 1'b1) || p != owner || err0 !== 1'b0 || err1 !== 1'b0)
                    $display("FAIL rnd_done: got done=%b%b err=%b%b expected port %0d only", done1, done0, err1, err0, owner);
                else n_pass++;
                if (p == 1) begin t = q1.pop_front(); fin1 = 1; end
                else        begin t = q0.pop_front(); fin0 = 1; end
                if (t.we) mmem[t.addr[5:2]] = t.data;
                else      mrd[p] = mmem[t.addr[5:2]];
                n_checks++;
                if (rdata0 !== mrd[0] || rdata1 !== mrd[1]) $display("FAIL rnd_rdata: got %h/%h expected %h/%h", rdata0, rdata1, mrd[0], mrd[1]);
                else n_pass++;
                mlast = p[0];
                owner = -1;
            end
            prev_psel = (PSEL === 1'b1);
            if ((fin0 || req0 == 0) && q0.size() != 0 && $urandom_range(0, 2) != 0) begin
                req0 = 1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
            end else if (fin0) req0 = 0;
            if ((fin1 || req1 == 0) && q1.size() != 0 && $urandom_range(0, 2) != 0) begin
                req1 = 1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
            end else if (fin1) req1 = 0;
            prev_req[0] = req0; prev_req[1] = req1;
            prev_done[0] = (done0 === 1'b1); prev_done[1] = (done1 === 1'b1);
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) $display("FAIL rnd_drain: got %0d/%0d left expected 0/0", q0.size(), q1.size());
        else n_pass++;
        req0 = 0; req1 = 0;
        @(negedge PCLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_wait_states();
        test_reset_mid_access();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
